// File: rtl/vid_timing_gen.sv
// Video timing generator: free-running h/v counters with registered sync/de/marker decode.
// Define VID_TIMING_GEN_SOF_EOL_EN to add the out_sof/out_eol stream markers.
module vid_timing_gen #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FRONT_PORCH = 110,
  parameter int H_SYNC_WIDTH  = 40,
  parameter int H_BACK_PORCH  = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FRONT_PORCH = 5,
  parameter int V_SYNC_WIDTH  = 5,
  parameter int V_BACK_PORCH  = 20,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int OUT_DELAY     = 1,
  localparam int H_FRAME = H_ACTIVE + H_FRONT_PORCH
                         + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int V_FRAME = V_ACTIVE + V_FRONT_PORCH
                         + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int HW = $clog2(H_FRAME),
  localparam int VW = $clog2(V_FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_enable,
  output logic [HW-1:0] out_hcnt,
  output logic [VW-1:0] out_vcnt,
  output logic          out_hsync,
  output logic          out_vsync,
  output logic          out_de,
  output logic          out_frame_start,
`ifdef VID_TIMING_GEN_SOF_EOL_EN
  output logic          out_sof,
  output logic          out_eol,
`endif
  output logic          out_line_start
);

  localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
  localparam int VS_END   = (VS_START + V_SYNC_WIDTH) % V_FRAME;
  localparam int ND       = (OUT_DELAY < 1) ? 1 : OUT_DELAY;

  localparam logic [HW-1:0] H_LAST_C = HW'(H_FRAME - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL_C  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_ST_C  = HW'(HS_START);
  localparam logic [HW-1:0] HS_EN_C  = HW'(HS_END);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_FRAME - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ST_C  = VW'(VS_START);
  localparam logic [VW-1:0] VS_EN_C  = VW'(VS_END);

  if (OUT_DELAY < 1 || OUT_DELAY > 4) begin : g_bad_delay
    $error("vid_timing_gen: OUT_DELAY must be 1..4");
  end
  if (H_FRONT_PORCH < 1 || H_SYNC_WIDTH < 1 || H_BACK_PORCH < 1 ||
      V_FRONT_PORCH < 1 || V_SYNC_WIDTH < 1 || V_BACK_PORCH < 1)
  begin : g_bad_timing
    $error("vid_timing_gen: porch and sync widths must be >= 1");
  end

  typedef struct packed {
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs;
    logic          vs;
    logic          de;
    logic          fs;
    logic          ls;
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    logic          sof;
    logic          eol;
`endif
  } stage_t;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          vs_q, vs_d;
  stage_t        stage_d;
  stage_t        pipe_q [ND];

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + 1'b1;
    end
  end

  // vs_d is both the flag's next value and vsync for the current count
  always_comb begin
    vs_d = vs_q;
    if (hcnt_q == HS_ST_C) begin
      if (vcnt_q == VS_ST_C)
        vs_d = 1'b1;
      else if (vcnt_q == VS_EN_C)
        vs_d = 1'b0;
    end
  end

  always_comb begin
    stage_d      = '0;
    stage_d.hcnt = hcnt_q;
    stage_d.vcnt = vcnt_q;
    stage_d.hs   = (hcnt_q >= HS_ST_C) && (hcnt_q < HS_EN_C);
    stage_d.vs   = vs_d;
    stage_d.de   = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    stage_d.ls   = (hcnt_q == '0);
    stage_d.fs   = (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    stage_d.sof  = stage_d.de && stage_d.fs;
    stage_d.eol  = stage_d.de && (hcnt_q == H_EOL_C);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      vs_q   <= 1'b0;
      for (int i = 0; i < ND; i++)
        pipe_q[i] <= '0;
    end else if (in_enable) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vs_q      <= vs_d;
      pipe_q[0] <= stage_d;
      for (int i = 1; i < ND; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Pipeline carries asserted-true syncs; polarity applied at the pins
  assign out_hcnt        = pipe_q[ND-1].hcnt;
  assign out_vcnt        = pipe_q[ND-1].vcnt;
  assign out_hsync       = pipe_q[ND-1].hs ^ ~HSYNC_POL;
  assign out_vsync       = pipe_q[ND-1].vs ^ ~VSYNC_POL;
  assign out_de          = pipe_q[ND-1].de;
  assign out_frame_start = pipe_q[ND-1].fs;
  assign out_line_start  = pipe_q[ND-1].ls;
`ifdef VID_TIMING_GEN_SOF_EOL_EN
  assign out_sof         = pipe_q[ND-1].sof;
  assign out_eol         = pipe_q[ND-1].eol;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Testbench for vid_timing_gen: small 16x8 raster, delays 1 and 3.
module tb_vid_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3, HF = 16;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1, VF = 8;

  typedef struct packed {
    logic [3:0] h;
    logic [2:0] v;
    logic hs, vs, de, fs, ls, sof, eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  bit   chk_on = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] o1_h, o3_h;
  logic [2:0] o1_v, o3_v;
  logic o1_hs, o1_vs, o1_de, o1_fs, o1_ls, o1_sof, o1_eol;
  logic o3_hs, o3_vs, o3_de, o3_fs, o3_ls, o3_sof, o3_eol;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .OUT_DELAY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_enable(en),
    .out_hcnt(o1_h), .out_vcnt(o1_v),
    .out_hsync(o1_hs), .out_vsync(o1_vs), .out_de(o1_de),
    .out_frame_start(o1_fs),
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    .out_sof(o1_sof), .out_eol(o1_eol),
`endif
    .out_line_start(o1_ls)
  );

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .OUT_DELAY(3)
  ) dut3 (
    .clk(clk), .rst(rst), .in_enable(en),
    .out_hcnt(o3_h), .out_vcnt(o3_v),
    .out_hsync(o3_hs), .out_vsync(o3_vs), .out_de(o3_de),
    .out_frame_start(o3_fs),
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    .out_sof(o3_sof), .out_eol(o3_eol),
`endif
    .out_line_start(o3_ls)
  );

`ifndef VID_TIMING_GEN_SOF_EOL_EN
  assign o1_sof = 1'b0;
  assign o1_eol = 1'b0;
  assign o3_sof = 1'b0;
  assign o3_eol = 1'b0;
`endif

  // Model: raster position as a linear pixel index within the frame
  int mh = 0, mv = 0;
  int hist_h[$];
  int hist_v[$];

  function automatic exp_t rst_val(bit hp, bit vp);
    exp_t e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    return e;
  endfunction

  function automatic exp_t decode(int h, int v, bit hp, bit vp);
    exp_t e;
    int p, vs0, vs1;
    bit hs_a, vs_a;
    p    = v * HF + h;
    vs0  = (VA + VFP) * HF + HA + HFP;
    vs1  = ((VA + VFP + VSW) % VF) * HF + HA + HFP;
    vs_a = (vs0 < vs1) ? (p >= vs0 && p < vs1) : (p >= vs0 || p < vs1);
    hs_a = (h >= HA + HFP) && (h < HA + HFP + HSW);
    e.h  = 4'(h);
    e.v  = 3'(v);
    e.hs = hs_a ? hp : ~hp;
    e.vs = vs_a ? vp : ~vp;
    e.de = (h < HA) && (v < VA);
    e.fs = (h == 0) && (v == 0);
    e.ls = (h == 0);
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    e.sof = e.de && e.fs;
    e.eol = e.de && (h == HA - 1);
`else
    e.sof = 1'b0;
    e.eol = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t expect_d(int d, bit hp, bit vp);
    int n = hist_h.size();
    if (n < d) return rst_val(hp, vp);
    return decode(hist_h[n-d], hist_v[n-d], hp, vp);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mh = 0;
      mv = 0;
      hist_h.delete();
      hist_v.delete();
    end else if (en) begin
      hist_h.push_back(mh);
      hist_v.push_back(mv);
      if (hist_h.size() > 4) begin
        void'(hist_h.pop_front());
        void'(hist_v.pop_front());
      end
      mh = mh + 1;
      if (mh == HF) begin
        mh = 0;
        mv = (mv + 1) % VF;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t a1, a3, e1, e3;
      a1 = '{o1_h, o1_v, o1_hs, o1_vs, o1_de, o1_fs, o1_ls, o1_sof, o1_eol};
      a3 = '{o3_h, o3_v, o3_hs, o3_vs, o3_de, o3_fs, o3_ls, o3_sof, o3_eol};
      e1 = expect_d(1, 1'b0, 1'b0);
      e3 = expect_d(3, 1'b1, 1'b1);
      checks += 2;
      if (a1 !== e1) begin
        failures++;
        $display("FAIL model_d1 t=%0t got=%h want=%h", $time, a1, e1);
      end
      if (a3 !== e3) begin
        failures++;
        $display("FAIL model_d3 t=%0t got=%h want=%h", $time, a3, e3);
      end
    end
  end

  task automatic chk(string name, int act, int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic tick(bit r, bit e);
    rst = r;
    en  = e;
    @(negedge clk);
  endtask

  task automatic wait_pos(int v, int h);
    int n = 0;
    while (!(int'(o1_v) == v && int'(o1_h) == h) && n < 300) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk($sformatf("reach_v%0d_h%0d", v, h), int'(n < 300), 1);
  endtask

  initial begin
    int ls_last, fs_last, ls_bad, de_bad, fs_gap, vs_fall, vs_rise;
    logic [15:0] hs1_mask, hs3_mask, de_mask, eol_mask;
    logic [15:0] snap;
    logic pv;
    int sof_n, eol_n, sof_bad;

    @(negedge clk);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk_on = 1'b1;
    chk("rst_hcnt", int'(o1_h), 0);
    chk("rst_hs_d1", int'(o1_hs), 1);
    chk("rst_vs_d1", int'(o1_vs), 1);
    chk("rst_de", int'(o1_de), 0);
    chk("rst_fs", int'(o1_fs), 0);
    chk("rst_hs_d3", int'(o3_hs), 0);
    chk("rst_vs_d3", int'(o3_vs), 0);

    tick(1'b0, 1'b1);
    chk("first_fs_d1", int'(o1_fs), 1);
    chk("first_de_d1", int'(o1_de), 1);
    chk("first_fs_d3", int'(o3_fs), 0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("lat_fs_d3", int'(o3_fs), 1);
    chk("lat_h_d1", int'(o1_h), 2);

    ls_last = -1; fs_last = -1; ls_bad = 0; de_bad = 0; fs_gap = -1;
    vs_fall = -1; vs_rise = -1;
    hs1_mask = '0; hs3_mask = '0; de_mask = '0;
    pv = o1_vs;
    for (int i = 0; i < 256; i++) begin
      tick(1'b0, 1'b1);
      if (o1_ls) begin
        if (ls_last >= 0 && i - ls_last != 16) ls_bad++;
        ls_last = i;
      end
      if (o1_fs) begin
        if (fs_last >= 0) fs_gap = i - fs_last;
        fs_last = i;
      end
      if (!o1_hs) hs1_mask[o1_h] = 1'b1;
      if (o3_hs) hs3_mask[o3_h] = 1'b1;
      if (o1_de) de_mask[o1_h] = 1'b1;
      if (o1_de && o1_v >= 3'd4) de_bad++;
      if (pv && !o1_vs) vs_fall = int'(o1_v) * HF + int'(o1_h);
      if (!pv && o1_vs) vs_rise = int'(o1_v) * HF + int'(o1_h);
      pv = o1_vs;
    end
    chk("ls_period", ls_bad, 0);
    chk("fs_period", fs_gap, 128);
    chk("hs_low_mask", int'(hs1_mask), 16'h1C00);
    chk("hs3_high_mask", int'(hs3_mask), 16'h1C00);
    chk("de_mask", int'(de_mask), 16'h00FF);
    chk("de_vblank", de_bad, 0);
    chk("vs_fall_pos", vs_fall, 5 * 16 + 10);
    chk("vs_rise_pos", vs_rise, 7 * 16 + 10);

    wait_pos(2, 6);
    snap = {o1_h, o1_v, o1_hs, o1_vs, o1_de, o1_fs, o1_ls,
            o3_hs, o3_vs};
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      chk("stall_hold",
          int'({o1_h, o1_v, o1_hs, o1_vs, o1_de, o1_fs, o1_ls, o3_hs, o3_vs}),
          int'(snap));
    end
    tick(1'b0, 1'b1);
    chk("resume_h", int'(o1_h), 7);
    chk("resume_v", int'(o1_v), 2);

    wait_pos(6, 3);
    chk("vs_asserted", int'(o1_vs), 0);
    tick(1'b1, 1'b1);
    chk("mid_rst_vs", int'(o1_vs), 1);
    chk("mid_rst_h", int'(o1_h), 0);
    chk("mid_rst_fs", int'(o1_fs), 0);
    chk("mid_rst_vs3", int'(o3_vs), 0);
    tick(1'b0, 1'b1);
    chk("restart_fs", int'(o1_fs), 1);
    chk("restart_v", int'(o1_v), 0);

    sof_n = 0; eol_n = 0; sof_bad = 0; eol_mask = '0;
    for (int i = 0; i < 128; i++) begin
      tick(1'b0, 1'b1);
      if (o1_sof) begin
        sof_n++;
        if (!(o1_fs && o1_de)) sof_bad++;
      end
      if (o1_eol) begin
        eol_n++;
        eol_mask[o1_h] = 1'b1;
        if (o1_v >= 3'd4) sof_bad++;
      end
    end
`ifdef VID_TIMING_GEN_SOF_EOL_EN
    chk("sof_count", sof_n, 1);
    chk("eol_count", eol_n, 4);
    chk("eol_mask", int'(eol_mask), 16'h0080);
    chk("marker_align", sof_bad, 0);
`endif

    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
Self-contained video timing generator. It holds free-running horizontal and vertical counters and derives hsync, vsync, data-enable and frame/line markers from them. Sync polarity and output latency are parametrised. It replaces the pairing of an external counter with a count-to-sync converter. It sits at the head of the video output path and feeds the pixel fetch logic and the TMDS/VGA encoder.

Parameters:
- H_ACTIVE, 1280: active pixels per line
- H_FRONT_PORCH, 110: pixels from end of active to hsync assert
- H_SYNC_WIDTH, 40: hsync pulse width in pixels
- H_BACK_PORCH, 220: pixels from hsync deassert to next active
- V_ACTIVE, 720: active lines per frame
- V_FRONT_PORCH, 5: lines from end of active to vsync assert
- V_SYNC_WIDTH, 5: vsync pulse width in lines
- V_BACK_PORCH, 20: lines from vsync deassert to next active
- HSYNC_POL, 0: asserted level of hsync (0 = active-low)
- VSYNC_POL, 0: asserted level of vsync (0 = active-low)
- OUT_DELAY, 1: output register stages, legal range 1..4
- Derived: H_FRAME = H_ACTIVE + all H porches/sync; V_FRAME likewise; HW = $clog2(H_FRAME); VW = $clog2(V_FRAME)

Ports:
- clk, input, 1: pixel clock
- rst, input, 1: synchronous active-high reset
- in_enable, input, 1: advance enable; low stalls the whole block
- out_hcnt, output, HW: pixel counter, aligned with the other outputs
- out_vcnt, output, VW: line counter, aligned
- out_hsync, output, 1: horizontal sync at HSYNC_POL level when asserted
- out_vsync, output, 1: vertical sync at VSYNC_POL level when asserted
- out_de, output, 1: active video
- out_frame_start, output, 1: single-cycle pulse at hcnt=0, vcnt=0
- out_line_start, output, 1: single-cycle pulse at every hcnt=0

Behaviour:
- Reset (rst=1 at a clk edge): counters go to 0. All pipeline stages clear. Outputs go to out_hcnt=0, out_vcnt=0, out_hsync=~HSYNC_POL, out_vsync=~VSYNC_POL, out_de=0, out_frame_start=0, out_line_start=0. Reset overrides in_enable. Reset mid-frame restarts at (0,0) with no partial sync pulse retained.
- Counters, advancing only when in_enable=1:
  - hcnt counts 0..H_FRAME-1, then wraps to 0.
  - On an hcnt wrap, vcnt increments. vcnt wraps from V_FRAME-1 to 0.
  - Simultaneous wrap of both counters (end of frame) gives (0,0) on the next cycle.
- Decode, computed combinationally from the current counters and registered through OUT_DELAY stages. All outputs share the same latency: the first stage captures the counters plus decode.
  - hsync is asserted for H_ACTIVE+H_FRONT_PORCH <= hcnt < H_ACTIVE+H_FRONT_PORCH+H_SYNC_WIDTH.
  - vsync edges are aligned to the hsync leading edge, VESA style. vsync asserts at (vcnt=V_ACTIVE+V_FRONT_PORCH, hcnt=H_ACTIVE+H_FRONT_PORCH). It deasserts at (vcnt=V_ACTIVE+V_FRONT_PORCH+V_SYNC_WIDTH, same hcnt), wrapping modulo V_FRAME. It is implemented as a registered set/clear flag, not a range decode.
  - de is asserted when hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - line_start: hcnt==0. frame_start: hcnt==0 and vcnt==0.
- Latency: counter state (h,v) appears on the outputs OUT_DELAY enabled cycles later.
- Stall: with in_enable=0, the counters and all pipeline stages hold and outputs are frozen. Pulses therefore persist while stalled. Downstream logic qualifies them with its own enable.
- Comparisons use widths HW/VW. Constants are elaborated as integer parameters, so there is no truncation for legal parameters.
- Elaboration error (`$error`) if OUT_DELAY is outside 1..4, or if any porch or sync width is below 1.

Optional Feature:
- Macro: VID_TIMING_GEN_SOF_EOL_EN
- Defined: adds two 1-bit outputs, both passing through the same OUT_DELAY pipeline.
  - out_sof: asserted when de=1, hcnt=0 and vcnt=0 (AXI4-Stream tuser).
  - out_eol: asserted when de=1 and hcnt=H_ACTIVE-1 (tlast).
  - Both reset to 0.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
Common small config: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_FRAME=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_FRAME=8); OUT_DELAY=1; polarities 0.
1. Hsync and de per line: release rst with in_enable=1. out_de is high for out_hcnt 0..7. out_hsync is low exactly for out_hcnt 10..12. out_line_start pulses every 16 cycles.
2. Vsync and frame period: out_vsync falls at (v=5,h=10) and rises at (v=7,h=10). out_frame_start pulses every 128 enabled cycles. out_de is never high for v>=4.
3. Latency and polarity: rerun with OUT_DELAY=3, HSYNC_POL=1, VSYNC_POL=1. Outputs are shifted by 2 further cycles relative to test 1. Syncs idle low and pulse high over the same counter ranges.
4. Stall: drop in_enable for 5 cycles at (v=2,h=6). All outputs hold their values. On resume the sequence continues at h=7 with no skipped or duplicated count.
5. Reset mid-operation: assert rst for 1 cycle while vsync is asserted at (v=6,h=3). Next cycle shows reset values (vsync deasserted). The following enabled cycles restart at (0,0) with frame_start.
6. With VID_TIMING_GEN_SOF_EOL_EN defined: out_sof is high once per 128 cycles, coincident with frame_start and de. out_eol is high at h=7 on v=0..3 only, giving 4 pulses per frame.
